// File: rtl/alu_result_collector.sv
// Receive-side buffer for ALU results: show-ahead FIFO of {result, status}, sticky flags, drop counter.
// Optional per-flag event counters are built when ALU_COLLECTOR_FLAGCNT_EN is defined.
module alu_result_collector #(
  parameter int M     = 8,
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_valid,
  input  logic [M-1:0]             i_result,
  input  logic [3:0]               i_status,
  input  logic                     i_rd_en,
  input  logic                     i_clr_sticky,
  output logic                     o_rd_valid,
  output logic [M-1:0]             o_rd_result,
  output logic [3:0]               o_rd_status,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [3:0]               o_sticky,
  output logic [CNT_W-1:0]         o_drop_cnt,
  output logic [4*CNT_W-1:0]       o_flag_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [M+3:0]     mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic [3:0]       sticky_reg;
  logic [3:0]       sticky_next;
  logic [CNT_W-1:0] drop_cnt_reg;
  logic [M+3:0]     head;
  logic             full;
  logic             empty;
  logic             rd_fire;
  logic             wr_fire;
  logic             drop;

  assign full  = (count_reg == CW'(DEPTH));
  assign empty = (count_reg == '0);

  // A pop while full frees the slot the same-cycle write lands in.
  assign rd_fire = i_rd_en && !empty;
  assign wr_fire = i_valid && (!full || i_rd_en);
  assign drop    = i_valid && full && !i_rd_en;

  assign sticky_next = (i_clr_sticky ? 4'b0000 : sticky_reg) | (i_valid ? i_status : 4'b0000);

  always_ff @(posedge i_clk) begin
    if (wr_fire) begin
      mem[wr_ptr_reg] <= {i_status, i_result};
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      sticky_reg   <= '0;
      drop_cnt_reg <= '0;
    end else begin
      if (wr_fire) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (rd_fire) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      case ({wr_fire, rd_fire})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
      sticky_reg <= sticky_next;
      if (drop && (drop_cnt_reg != '1)) begin
        drop_cnt_reg <= drop_cnt_reg + CNT_W'(1);
      end
    end
  end

  // Memory contents are never cleared; the empty gate hides stale or unwritten slots.
  assign head        = mem[rd_ptr_reg];
  assign o_rd_valid  = !empty;
  assign o_rd_result = empty ? '0 : head[M-1:0];
  assign o_rd_status = empty ? 4'b0000 : head[M+3:M];
  assign o_count     = count_reg;
  assign o_full      = full;
  assign o_empty     = empty;
  assign o_sticky    = sticky_reg;
  assign o_drop_cnt  = drop_cnt_reg;

`ifdef ALU_COLLECTOR_FLAGCNT_EN
  logic [CNT_W-1:0] flag_cnt_reg [4];

  for (genvar gi = 0; gi < 4; gi++) begin : g_flag_cnt
    logic hit;
    assign hit = i_valid && i_status[gi];

    // Clear has lower priority than a same-cycle event, matching the sticky flags.
    always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
        flag_cnt_reg[gi] <= '0;
      end else if (i_clr_sticky) begin
        flag_cnt_reg[gi] <= CNT_W'(hit);
      end else if (hit && (flag_cnt_reg[gi] != '1)) begin
        flag_cnt_reg[gi] <= flag_cnt_reg[gi] + CNT_W'(1);
      end
    end

    assign o_flag_cnt[gi*CNT_W +: CNT_W] = flag_cnt_reg[gi];
  end
`else
  assign o_flag_cnt = '0;
`endif

endmodule

// File: tb/tb_alu_result_collector.sv
// Self-checking bench for alu_result_collector: vector table, corner sequences, random traffic vs a queue model.
module tb_alu_result_collector;
  localparam int M     = 8;
  localparam int DEPTH = 4;
  localparam int CNT_W = 8;
  localparam int SAT   = (1 << CNT_W) - 1;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   valid;
  logic [M-1:0]           result;
  logic [3:0]             status;
  logic                   rd_en;
  logic                   clr;
  logic                   rd_valid;
  logic [M-1:0]           rd_result;
  logic [3:0]             rd_status;
  logic [$clog2(DEPTH):0] count;
  logic                   full;
  logic                   empty;
  logic [3:0]             sticky;
  logic [CNT_W-1:0]       drop_cnt;
  logic [4*CNT_W-1:0]     flag_cnt;

  alu_result_collector #(.M(M), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .i_clk(clk), .i_reset(rst), .i_valid(valid), .i_result(result), .i_status(status),
    .i_rd_en(rd_en), .i_clr_sticky(clr), .o_rd_valid(rd_valid), .o_rd_result(rd_result),
    .o_rd_status(rd_status), .o_count(count), .o_full(full), .o_empty(empty),
    .o_sticky(sticky), .o_drop_cnt(drop_cnt), .o_flag_cnt(flag_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [M-1:0] r;
    logic [3:0]   s;
  } ent_t;

  typedef struct {
    logic         v;
    logic [M-1:0] r;
    logic [3:0]   s;
    logic         rd;
    logic         c;
    logic         e_rv;
    logic [M-1:0] e_res;
    int           e_cnt;
    logic         e_full;
    int           e_drop;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int txn    = 0;

  // Reference model: queue of pending entries plus plain integer counters.
  ent_t       q[$];
  logic [3:0] m_sticky;
  int         m_drop;
  int         m_fc[4];

  task automatic model_reset();
    q.delete();
    m_sticky = 4'b0000;
    m_drop   = 0;
    for (int k = 0; k < 4; k++) m_fc[k] = 0;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s (txn %0d): got %0h, expected %0h", name, txn, act, want);
    end
  endtask

  task automatic check_model();
    ent_t        h;
    logic [31:0] fc_exp;
    h = (q.size() > 0) ? q[0] : '0;
    fc_exp = '0;
`ifdef ALU_COLLECTOR_FLAGCNT_EN
    for (int k = 0; k < 4; k++) fc_exp[k*CNT_W +: CNT_W] = CNT_W'(m_fc[k]);
`endif
    chk("rd_valid",  32'(rd_valid),  32'(q.size() > 0));
    chk("rd_result", 32'(rd_result), 32'(h.r));
    chk("rd_status", 32'(rd_status), 32'(h.s));
    chk("count",     32'(count),     32'(q.size()));
    chk("full",      32'(full),      32'(q.size() == DEPTH));
    chk("empty",     32'(empty),     32'(q.size() == 0));
    chk("sticky",    32'(sticky),    32'(m_sticky));
    chk("drop_cnt",  32'(drop_cnt),  32'(m_drop));
    chk("flag_cnt",  32'(flag_cnt),  fc_exp);
  endtask

  task automatic step(input logic v, input logic [M-1:0] r, input logic [3:0] s,
                      input logic rd, input logic c);
    valid = v; result = r; status = s; rd_en = rd; clr = c;
    @(posedge clk);
    if (rd && q.size() > 0) void'(q.pop_front());
    if (v) begin
      if (q.size() < DEPTH) q.push_back({r, s});
      else if (m_drop < SAT) m_drop++;
    end
    m_sticky = (c ? 4'b0000 : m_sticky) | (v ? s : 4'b0000);
    for (int k = 0; k < 4; k++) begin
      if (c) m_fc[k] = 0;
      if (v && s[k] && m_fc[k] < SAT) m_fc[k]++;
    end
    #1;
    valid = 1'b0; rd_en = 1'b0; clr = 1'b0;
    txn++;
    $display("txn %0d: v=%0b res=%02h st=%04b rd=%0b clr=%0b -> cnt=%0d head=%02h drop=%0d",
             txn, v, r, s, rd, c, count, rd_result, drop_cnt);
    check_model();
  endtask

  task automatic sync_reset();
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  vec_t tbl[16];

  initial begin
    // idle pops, pass-through, then fill/overflow with wrap-around reads
    tbl[0]  = '{1'b0, 8'h00, 4'b0000, 1'b1, 1'b0, 1'b0, 8'h00, 0, 1'b0, 0};
    tbl[1]  = '{1'b0, 8'h00, 4'b0000, 1'b1, 1'b0, 1'b0, 8'h00, 0, 1'b0, 0};
    tbl[2]  = '{1'b0, 8'h00, 4'b0000, 1'b1, 1'b0, 1'b0, 8'h00, 0, 1'b0, 0};
    tbl[3]  = '{1'b1, 8'h05, 4'b0001, 1'b0, 1'b0, 1'b1, 8'h05, 1, 1'b0, 0};
    tbl[4]  = '{1'b0, 8'h00, 4'b0000, 1'b1, 1'b0, 1'b0, 8'h00, 0, 1'b0, 0};
    tbl[5]  = '{1'b1, 8'h01, 4'b0000, 1'b0, 1'b0, 1'b1, 8'h01, 1, 1'b0, 0};
    tbl[6]  = '{1'b1, 8'h02, 4'b0000, 1'b0, 1'b0, 1'b1, 8'h01, 2, 1'b0, 0};
    tbl[7]  = '{1'b1, 8'h03, 4'b0000, 1'b0, 1'b0, 1'b1, 8'h01, 3, 1'b0, 0};
    tbl[8]  = '{1'b1, 8'h04, 4'b0000, 1'b0, 1'b0, 1'b1, 8'h01, 4, 1'b1, 0};
    tbl[9]  = '{1'b1, 8'h05, 4'b0000, 1'b0, 1'b0, 1'b1, 8'h01, 4, 1'b1, 1};
    tbl[10] = '{1'b1, 8'h06, 4'b0000, 1'b0, 1'b0, 1'b1, 8'h01, 4, 1'b1, 2};
    tbl[11] = '{1'b0, 8'h00, 4'b0000, 1'b1, 1'b0, 1'b1, 8'h02, 3, 1'b0, 2};
    tbl[12] = '{1'b0, 8'h00, 4'b0000, 1'b1, 1'b0, 1'b1, 8'h03, 2, 1'b0, 2};
    tbl[13] = '{1'b0, 8'h00, 4'b0000, 1'b1, 1'b0, 1'b1, 8'h04, 1, 1'b0, 2};
    tbl[14] = '{1'b0, 8'h00, 4'b0000, 1'b1, 1'b0, 1'b0, 8'h00, 0, 1'b0, 2};
    tbl[15] = '{1'b0, 8'h00, 4'b0000, 1'b1, 1'b0, 1'b0, 8'h00, 0, 1'b0, 2};

    rst = 1'b1; valid = 1'b0; result = '0; status = '0; rd_en = 1'b0; clr = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check_model();
    chk("reset_empty", 32'(empty), 32'd1);

    for (int i = 0; i < 16; i++) begin
      step(tbl[i].v, tbl[i].r, tbl[i].s, tbl[i].rd, tbl[i].c);
      chk("tbl_rd_valid", 32'(rd_valid),  32'(tbl[i].e_rv));
      chk("tbl_rd_result", 32'(rd_result), 32'(tbl[i].e_res));
      chk("tbl_count",    32'(count),     32'(tbl[i].e_cnt));
      chk("tbl_full",     32'(full),      32'(tbl[i].e_full));
      chk("tbl_drop",     32'(drop_cnt),  32'(tbl[i].e_drop));
    end

    // Full FIFO with simultaneous write and pop
    sync_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 8'h10 + 8'(i), 4'b0000, 1'b0, 1'b0);
    step(1'b1, 8'h14, 4'b0000, 1'b1, 1'b0);
    chk("simul_drop",  32'(drop_cnt), 32'd0);
    chk("simul_count", 32'(count),    32'd4);
    for (int i = 0; i < 4; i++) begin
      chk("simul_head", 32'(rd_result), 32'(8'h11 + 8'(i)));
      step(1'b0, 8'h00, 4'b0000, 1'b1, 1'b0);
    end
    chk("simul_empty", 32'(empty), 32'd1);

    // Sticky clear with a same-cycle flag
    step(1'b1, 8'hAA, 4'b0100, 1'b0, 1'b0);
    step(1'b1, 8'hBB, 4'b0010, 1'b0, 1'b1);
    chk("sticky_clr", 32'(sticky), 32'b0010);
`ifdef ALU_COLLECTOR_FLAGCNT_EN
    chk("flag_cnt1", 32'(flag_cnt[1*CNT_W +: CNT_W]), 32'd1);
    chk("flag_cnt2", 32'(flag_cnt[2*CNT_W +: CNT_W]), 32'd0);
`else
    chk("flag_cnt_off", 32'(flag_cnt), 32'd0);
`endif

    // Asynchronous reset between edges with three entries queued
    step(1'b1, 8'hCC, 4'b1000, 1'b0, 1'b0);
    chk("pre_reset_count", 32'(count), 32'd3);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_model();
    chk("async_reset_count", 32'(count), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    step(1'b1, 8'h7E, 4'b0000, 1'b0, 1'b0);
    chk("post_reset_head",  32'(rd_result), 32'h7E);
    chk("post_reset_count", 32'(count),     32'd1);
    step(1'b0, 8'h00, 4'b0000, 1'b1, 1'b0);
    chk("post_reset_empty", 32'(empty), 32'd1);

    // Saturation of drop and flag counters
    sync_reset();
    for (int i = 0; i < DEPTH + SAT + 5; i++) step(1'b1, 8'(i), 4'b1111, 1'b0, 1'b0);
    chk("drop_sat", 32'(drop_cnt), 32'(SAT));

    // Random traffic against the model
    sync_reset();
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 99) < 55, 8'($urandom), 4'($urandom),
           $urandom_range(0, 99) < 45, $urandom_range(0, 99) < 6);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
